binary_to_bcd_seq: RTL and testbench

//  Iterative binary-to-packed-BCD converter using shift-add-3 (double dabble), one bit per clock.

---
 rtl/binary_to_bcd_seq.sv | 163 ++++++++++++++++
 tb/tb_binary_to_bcd_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: iterative binary to packed-BCD converter (shift-add-3),
// one binary bit consumed per clock, valid/ready handshake on both sides.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   bin is valid
//   in_ready   out  converter can accept (IDLE only)
//   bin        in   unsigned binary operand, BIN_W bits
//   out_valid  out  bcd holds a finished result
//   out_ready  in   downstream accepts the result
//   bcd        out  packed BCD, digit k at bcd[4k+3:4k], k=0 least significant
//   sig_digits out  count of significant digits (min 1), only when
//                   BCD_DIGIT_COUNT_EN is defined
//
// Optional feature macro: BCD_DIGIT_COUNT_EN
module binary_to_bcd_seq #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BIN_W-1:0]            bin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4*DIGITS-1:0]         bcd
`ifdef BCD_DIGIT_COUNT_EN
    ,
    output logic [$clog2(DIGITS+1)-1:0] sig_digits
`endif
);

    localparam int unsigned BCD_W      = 4 * DIGITS;
    localparam int unsigned CW         = $clog2(BIN_W + 1);
    localparam int unsigned MIN_DIGITS = (BIN_W * 301 + 999) / 1000;

    // Too few digits would let the accumulator overflow silently.
    if (DIGITS < MIN_DIGITS) begin : g_digits_check
        $error("binary_to_bcd_seq: DIGITS too small for BIN_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               out_valid_q, out_valid_d;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted;

`ifdef BCD_DIGIT_COUNT_EN
    localparam int unsigned SW = $clog2(DIGITS + 1);
    logic [SW-1:0]      sig_q, sig_d;
    logic [SW-1:0]      sig_calc;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            acc_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef BCD_DIGIT_COUNT_EN
            sig_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
`ifdef BCD_DIGIT_COUNT_EN
            sig_q       <= sig_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        bcd_d       = bcd_q;
        out_valid_d = out_valid_q;
        adj         = acc_q;
`ifdef BCD_DIGIT_COUNT_EN
        sig_d       = sig_q;
        sig_calc    = SW'(1);
`endif

        // Add-3 correction on every digit independently, then shift in the binary MSB.
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = 4'(acc_q[4*k +: 4] + 4'd3);
            end
        end
        shifted = (adj << 1) | BCD_W'(shreg_q[BIN_W-1]);

`ifdef BCD_DIGIT_COUNT_EN
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (shifted[4*k +: 4] != 4'd0) begin
                sig_calc = SW'(k + 1);
            end
        end
`endif

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    shreg_d = bin;
                    acc_d   = '0;
                    cnt_d   = CW'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = shifted;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CW'(1);
                // Last bit consumed on this edge: publish the result.
                if (cnt_q == CW'(1)) begin
                    bcd_d       = shifted;
                    out_valid_d = 1'b1;
`ifdef BCD_DIGIT_COUNT_EN
                    sig_d       = sig_calc;
`endif
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
`ifdef BCD_DIGIT_COUNT_EN
    assign sig_digits = sig_q;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed testbench for binary_to_bcd_seq (BIN_W=32, DIGITS=10).
module tb_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] bcd;
`ifdef BCD_DIGIT_COUNT_EN
    logic [3:0]  sig_digits;
`endif

    int checks = 0;
    int errors = 0;

    binary_to_bcd_seq #(.BIN_W(32), .DIGITS(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd)
`ifdef BCD_DIGIT_COUNT_EN
        ,
        .sig_digits(sig_digits)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a conversion at a negedge, check latency edges +31/+32, then the result.
    task automatic convert(input string tag, input logic [31:0] v,
                           input logic [39:0] exp_bcd, input int exp_sig);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        bin      = v;
        @(negedge clk);            // accepting edge has passed
        in_valid = 1'b0;
        bin      = '0;
        repeat (31) @(negedge clk);
        check({tag, "_valid_at_31"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid_at_32"}, 64'(out_valid), 64'd1);
        check({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
`ifdef BCD_DIGIT_COUNT_EN
        check({tag, "_sig"}, 64'(sig_digits), 64'(exp_sig));
`else
        if (exp_sig < 0) $display("unused");
`endif
    endtask

    // Complete the output handshake and confirm return to IDLE.
    task automatic drain(input string tag, input logic [39:0] exp_bcd);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_drain_bcd_kept"}, 64'(bcd), 64'(exp_bcd));
    endtask

    logic [31:0] vals [3];
    int          acc_cyc [3];
    int          n_acc;
    int          n_res;
    int          cyc;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin       = '0;
        vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        convert("zero", 32'd0, 40'h0000000000, 1);
        drain("zero", 40'h0000000000);

        convert("max", 32'hFFFFFFFF, 40'h4294967295, 10);
        drain("max", 40'h4294967295);

        convert("d12345", 32'd12345, 40'h0000012345, 5);

        // Stall in DONE; an in_valid pulse must be ignored.
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            bin      = 32'd7;
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_bcd", 64'(bcd), 64'h0000012345);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        bin      = '0;
        drain("d12345", 40'h0000012345);
        // If bin=7 had been captured the converter would not be idle now.
        @(negedge clk);
        check("no_capture_ready", 64'(in_ready), 64'd1);
        check("no_capture_valid", 64'(out_valid), 64'd0);

        // Reset in the middle of a conversion
        in_valid = 1'b1;
        bin      = 32'd999;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        convert("d99", 32'd99, 40'h0000000099, 2);
        drain("d99", 40'h0000000099);

        // Back-to-back conversions with both sides always ready
        n_acc = 0;
        n_res = 0;
        cyc   = 0;
        out_ready = 1'b1;
        while (n_res < 3 && cyc < 300) begin
            if (n_acc < 3) begin
                in_valid = 1'b1;
                bin      = vals[n_acc];
            end else begin
                in_valid = 1'b0;
                bin      = '0;
            end
            if (out_valid) begin
                check("b2b_result", 64'(bcd), 64'(n_res + 1));
                n_res++;
            end
            if (in_ready && in_valid) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_all_results", 64'(n_res), 64'd3);
        check("b2b_spacing_01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd34);
        check("b2b_spacing_12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
